// File: rtl/serial_mult_seq.sv
// serial_mult_seq: sequential shift-add multiplier producing a 2*WIDTH-bit
// product from two WIDTH-bit operands. Operands are converted to magnitudes
// at accept time, multiplied unsigned, and the sign is reapplied on the
// final edge. RUN ends early once the remaining multiplier bits are zero.
module serial_mult_seq #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           state
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q,  mplr_d;
    logic [PW-1:0]    acc_q,   acc_d;
    logic             neg_q,   neg_d;
    logic [PW-1:0]    product_q, product_d;

    logic             signed_mode;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             accept;
    logic             finish;

    // Magnitude conversion of the operands; the most negative value maps to
    // 2^(WIDTH-1), which still fits the unsigned WIDTH-bit registers.
    always_comb begin
        signed_mode = SIGNED_EN & is_signed;
        a_mag       = (signed_mode && a[WIDTH-1]) ? ('0 - a) : a;
        b_mag       = (signed_mode && b[WIDTH-1]) ? ('0 - b) : b;
    end

    assign accept = (state_q == IDLE) && in_valid;
    assign finish = (state_q == RUN) && (mplr_q == '0);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE accepts, RUN exits when multiplier is exhausted,
    // DONE waits for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)       state_d = RUN;
            RUN:  if (mplr_q == '0)   state_d = DONE;
            DONE: if (out_ready)      state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Handshake outputs decode from the state register only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: load on accept, shift-add while RUN, and apply the
    // sign to the accumulator on the edge that leaves RUN.
    always_comb begin
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        product_d = product_q;
        if (accept) begin
            mcand_d = {{WIDTH{1'b0}}, a_mag};
            mplr_d  = b_mag;
            acc_d   = '0;
            neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (finish) begin
            product_d = neg_q ? ('0 - acc_q) : acc_q;
        end else if (state_q == RUN) begin
            if (mplr_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
        end
    end

    // Datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign state   = state_q;

endmodule

// File: tb/tb_serial_mult_seq.sv
// Self-checking bench for serial_mult_seq (WIDTH=8): directed vector table,
// hand-written backpressure/reset sequences, an unsigned-only instance, and
// a randomized scoreboard against a plain-arithmetic reference multiply.
module tb_serial_mult_seq;

    logic        clk;
    logic        resetn;
    logic        in_valid, in_ready;
    logic [7:0]  a, b;
    logic        is_signed;
    logic        out_valid, out_ready;
    logic [15:0] product;
    logic [1:0]  state;

    logic        in_valid_u, in_ready_u;
    logic [7:0]  a_u, b_u;
    logic        is_signed_u;
    logic        out_valid_u, out_ready_u;
    logic [15:0] product_u;
    logic [1:0]  state_u;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    serial_mult_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .state(state)
    );

    serial_mult_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) u_dut_u (
        .clk(clk), .resetn(resetn), .in_valid(in_valid_u), .in_ready(in_ready_u),
        .a(a_u), .b(b_u), .is_signed(is_signed_u), .out_valid(out_valid_u),
        .out_ready(out_ready_u), .product(product_u), .state(state_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: product from plain integer arithmetic on the interpreted values.
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic sg);
        int sx, sy;
        sx = sg ? int'($signed(x)) : int'(x);
        sy = sg ? int'($signed(y)) : int'(y);
        return 16'(sx * sy);
    endfunction

    // Reference: RUN length from the magnitude of b.
    function automatic int ref_k(input logic [7:0] y, input logic sg);
        int m, idx;
        m = sg ? int'($signed(y)) : int'(y);
        if (m < 0) m = -m;
        if (m == 0) return 1;
        idx = 0;
        while (m > 1) begin
            m = m >> 1;
            idx++;
        end
        return idx + 2;
    endfunction

    // One complete operation on the signed-capable DUT with latency check.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic isg,
                          input logic [15:0] ep, input int ek, input string nm);
        int n;
        @(negedge clk);
        chk({nm, " in_ready"}, 32'(in_ready), 1);
        in_valid = 1'b1; a = ia; b = ib; is_signed = isg; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); is_signed = ~isg;
        for (n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        chk({nm, " latency"}, 32'(n), 32'(ek));
        chk({nm, " product"}, 32'(product), 32'(ep));
        chk({nm, " state"}, 32'(state), 2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " back idle"}, 32'(state), 0);
        chk({nm, " hold in idle"}, 32'(product), 32'(ep));
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sg;
        logic [15:0] p;
        int          k;
    } vec_t;

    typedef struct {
        logic [15:0] p;
        int          acc;
        int          k;
    } pend_t;

    initial begin : main
        vec_t  vt[7];
        pend_t q[$];
        pend_t e;
        int    issued;
        int    n;
        logic  prev_ov;
        logic [7:0] ra, rb;
        logic  rs;

        vt[0] = '{8'd13,  8'd11,  1'b0, 16'd143,   5};
        vt[1] = '{8'hF9,  8'd6,   1'b1, 16'hFFD6,  4};
        vt[2] = '{8'h80,  8'h80,  1'b1, 16'h4000,  9};
        vt[3] = '{8'hFF,  8'h00,  1'b0, 16'h0000,  1};
        vt[4] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01,  9};
        vt[5] = '{8'h00,  8'h80,  1'b0, 16'h0000,  9};
        vt[6] = '{8'd5,   8'hFD,  1'b1, 16'hFFF1,  3};

        resetn = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
        in_valid_u = 1'b0; a_u = '0; b_u = '0; is_signed_u = 1'b0; out_ready_u = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready",  32'(in_ready), 1);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset product",   32'(product), 0);
        chk("reset state",     32'(state), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Directed table.
        for (int i = 0; i < 7; i++)
            run_op(vt[i].a, vt[i].b, vt[i].sg, vt[i].p, vt[i].k, $sformatf("vec%0d", i));

        // Backpressure: hold DONE, offer new operands, then release.
        @(negedge clk);
        in_valid = 1'b1; a = 8'd13; b = 8'd11; is_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp state", 32'(state), 2);
            chk("bp out_valid", 32'(out_valid), 1);
            chk("bp product", 32'(product), 143);
            chk("bp in_ready", 32'(in_ready), 0);
            in_valid = 1'(i % 2); a = 8'd99; b = 8'd77;
        end
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release idle", 32'(state), 0);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp product after", 32'(product), 143);

        // Reset in the middle of RUN.
        @(negedge clk);
        in_valid = 1'b1; a = 8'd200; b = 8'd255; is_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0; in_valid = 1'b1; a = 8'd7; b = 8'd7;
        @(posedge clk); #1;
        chk("rst mid state", 32'(state), 0);
        chk("rst mid product", 32'(product), 0);
        chk("rst mid out_valid", 32'(out_valid), 0);
        @(negedge clk);
        resetn = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("rst no stale out_valid", 32'(out_valid), 0);
        run_op(8'd3, 8'd5, 1'b0, 16'd15, 4, "after reset");

        // Unsigned-only instance ignores is_signed.
        @(negedge clk);
        in_valid_u = 1'b1; a_u = 8'hF9; b_u = 8'd6; is_signed_u = 1'b1;
        @(posedge clk); #1;
        in_valid_u = 1'b0;
        for (n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (out_valid_u) break;
        end
        chk("unsigned_en latency", 32'(n), 4);
        chk("unsigned_en product", 32'(product_u), 1494);
        out_ready_u = 1'b1;
        @(posedge clk); #1;
        out_ready_u = 1'b0;
        chk("unsigned_en idle", 32'(state_u), 0);

        // Randomized back-to-back traffic with consumer stalls.
        issued = 0;
        prev_ov = 1'b0;
        cyc = 0;
        for (int t = 0; t < 60000 && (issued < 1000 || q.size() != 0); t++) begin
            @(negedge clk);
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) chk("rnd spurious out_valid", 1, 0);
                else chk("rnd latency", 32'(cyc - q[0].acc), 32'(q[0].k));
            end
            prev_ov = out_valid;
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready && q.size() != 0) begin
                chk("rnd product", 32'(product), 32'(q[0].p));
                void'(q.pop_front());
            end
            if (in_ready && issued < 1000 && $urandom_range(0, 3) != 0) begin
                ra = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom);
                rb = ($urandom_range(0, 9) == 0) ? 8'h80 :
                     ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
                rs = 1'($urandom);
                in_valid = 1'b1; a = ra; b = rb; is_signed = rs;
                e.p = ref_mul(ra, rb, rs);
                e.k = ref_k(rb, rs);
                e.acc = cyc + 1;
                q.push_back(e);
                issued++;
            end else begin
                in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
            end
            @(posedge clk);
            cyc++;
        end
        if (issued < 1000 || q.size() != 0) chk("rnd completion", 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_mult_seq.md
# serial_mult_seq

Parametrised sequential shift-add multiplier: a self-contained control FSM plus datapath producing a 2·WIDTH-bit product from two WIDTH-bit operands. It supports signed and unsigned operation, valid/ready handshakes on both input and output, and early termination once the remaining multiplier bits are zero. It is the drop-in arithmetic unit for blocks that need an area-cheap multiply and can tolerate variable latency.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- SIGNED_EN, 1, 1 = honour `is_signed`; 0 = `is_signed` ignored, always unsigned.
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier; its magnitude sets latency.
- is_signed  input  1  1 = a, b and product are two's complement.
- out_valid  output  1  product valid (high only in DONE).
- out_ready  input  1  consumer takes product.
- product  output  2*WIDTH  result; holds last value until the next result.
- state  output  2  0 IDLE, 1 RUN, 2 DONE; 3 unreachable.

## Operation
- IDLE: in_ready=1. On in_valid & in_ready at an edge, register mcand = zero-extended |a| (2·WIDTH bits), mplr = |b| (WIDTH bits), acc = 0, neg = s & (a[MSB] ^ b[MSB]) with s = SIGNED_EN & is_signed. Go to RUN. Unsigned: |x| = x.
- Magnitude of the most negative value −2^(WIDTH−1) is 2^(WIDTH−1) and fits the unsigned WIDTH-bit mplr/mcand. No overflow is possible: every product fits 2·WIDTH bits signed or unsigned.
- RUN, each edge:
  - If mplr == 0: product <= neg ? −acc : acc (2·WIDTH-bit two's complement); go to DONE.
  - Else: if mplr[0], acc <= acc + mcand (mod 2^(2·WIDTH)); mcand <= mcand << 1; mplr <= mplr >> 1.
- DONE: out_valid=1, product stable. On out_ready at an edge go to IDLE. Operands are not accepted in DONE, even with out_ready high in the same cycle.
- Inputs a, b and is_signed are sampled only at the accepting edge; later changes have no effect.
- Reset (resetn=0 at an edge), from any state including mid-RUN or DONE: state=IDLE, product=0, acc/mcand/mplr/neg=0, in-flight operation discarded, no out_valid pulse. in_valid during reset is ignored.
- Reset values of outputs: in_ready=1, out_valid=0, product=0, state=0.

## Timing
- in_ready, out_valid and state decode combinationally from the state register only; there are no combinational paths from inputs to outputs.
- Accept edge E0. RUN lasts k edges: k = 1 if |b| = 0, else k = msb_index(|b|) + 2. Maximum k = WIDTH+1.
- out_valid rises after edge Ek. Minimum issue interval = k+2 cycles, with out_ready held high.
- product updates only at the RUN→DONE edge and is unchanged through DONE and the following IDLE.
- Backpressure: DONE persists indefinitely while out_ready=0, with product and out_valid stable.

## Test plan
- Unsigned, WIDTH=8: a=13, b=11, is_signed=0 -> product=16'd143; out_valid asserts 5 cycles after accept (k=5); back in IDLE next edge with out_ready=1.
- Signed: a=−7 (8'hF9), b=6 -> product=16'hFFD6 (−42), k=4. Also a=−128, b=−128 -> 16'h4000, k=9. With SIGNED_EN=0, a=8'hF9, b=6 -> 16'd1494.
- Boundaries: b=0, a=8'hFF -> product=0, k=1. a=b=8'hFF unsigned -> 16'hFE01, k=9. a=0, b=8'h80 -> 0, k=9.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> state=2, out_valid=1, product constant. in_valid pulses with new operands are not accepted (in_ready=0). Release -> IDLE.
- Reset mid-RUN: assert resetn=0 for 1 edge 2 cycles after accept -> state=0, product=0, out_valid stays 0. The next operation (3×5) yields 15 correctly.
- Back-to-back random: 1000 random (a, b, is_signed) with random out_ready stalls, compared against a reference multiply. Each latency checked against the k formula, and output order matches input order.
